sif_xa_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single SIF XA port of the DUT between two requesters. It turns requester write/read commands into exactly-timed `xa_wr_s`/`xa_rd_s` strobes and never drives the illegal both-strobes combination. It returns read data tagged with the issuing requester and keeps wrapping transaction counters for the environment's reference and scoreboard.

---
 rtl/sif_xa_arbiter.sv | 152 +++++++++++++++
 tb/tb_sif_xa_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sif_xa_arbiter.sv
// sif_xa_arbiter: round-robin arbiter and sequencer sharing one SIF XA port between two
// requesters. Issues exactly-timed write/read strobes (never both), returns read data tagged
// with the issuing requester, and keeps wrapping write/read completion counters.
module sif_xa_arbiter #(
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 2   // 1..15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_wr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_wr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rd_valid,
  output logic          rd_id,
  output logic [DW-1:0] rd_data,
  output logic          xa_wr_s,
  output logic          xa_rd_s,
  output logic [DW-1:0] xa_wdata,
  input  logic [DW-1:0] xa_rd_data,
  output logic          busy,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
);

  localparam logic [3:0] LatInit = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdWait} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            cur_id_q, cur_id_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_id_q, rd_id_d;
  logic            rd_valid_q, rd_valid_d;
  logic [3:0]      lat_q, lat_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [15:0]     rd_cnt_q, rd_cnt_d;
  logic            wr_s_q, rd_s_q;
  logic            grant0, grant1;
  logic            win_wr;

  // Arbitration: only in IDLE; on a tie the requester that did not win last time goes.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Next-state and datapath updates for the command sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    rd_id_d      = rd_id_q;
    rd_valid_d   = 1'b0;
    lat_d        = lat_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    win_wr       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          cur_id_d     = grant1;
          last_grant_d = grant1;
          wdata_d      = grant1 ? req1_wdata : req0_wdata;
          win_wr       = grant1 ? req1_wr : req0_wr;
          state_d      = win_wr ? StWrite : StRead;
        end
      end
      StWrite: begin
        wr_cnt_d = wr_cnt_q + 16'd1;
        state_d  = StIdle;
      end
      StRead: begin
        lat_d   = LatInit;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (lat_q != 4'd0) begin
          lat_d = lat_q - 4'd1;
        end else begin
          rd_data_d  = xa_rd_data;
          rd_id_d    = cur_id_q;
          rd_valid_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + 16'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; strobes are registered decodes of the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      rd_id_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      lat_q        <= 4'd0;
      wr_cnt_q     <= 16'd0;
      rd_cnt_q     <= 16'd0;
      wr_s_q       <= 1'b0;
      rd_s_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      rd_id_q      <= rd_id_d;
      rd_valid_q   <= rd_valid_d;
      lat_q        <= lat_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_s_q       <= (state_d == StWrite);
      rd_s_q       <= (state_d == StRead);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xa_wr_s    = wr_s_q;
  assign xa_rd_s    = rd_s_q;
  assign xa_wdata   = wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_id      = rd_id_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q != StIdle);
  assign wr_cnt     = wr_cnt_q;
  assign rd_cnt     = rd_cnt_q;

endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Directed self-checking bench for sif_xa_arbiter (DW=16, RD_LAT=2).
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_sif_xa_arbiter;

  localparam int unsigned DW     = 16;
  localparam int unsigned RD_LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_wr, req0_ready;
  logic          req1_valid, req1_wr, req1_ready;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          rd_valid, rd_id;
  logic [DW-1:0] rd_data;
  logic          xa_wr_s, xa_rd_s;
  logic [DW-1:0] xa_wdata, xa_rd_data;
  logic          busy;
  logic [15:0]   wr_cnt, rd_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  sif_xa_arbiter #(.DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_wr    (req0_wr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_wr    (req1_wr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rd_valid   (rd_valid),
    .rd_id      (rd_id),
    .rd_data    (rd_data),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_wdata   (xa_wdata),
    .xa_rd_data (xa_rd_data),
    .busy       (busy),
    .wr_cnt     (wr_cnt),
    .rd_cnt     (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_wr = 1'b0; req0_wdata = '0;
    req1_valid = 1'b0; req1_wr = 1'b0; req1_wdata = '0;
    xa_rd_data = '0;

    // Reset values
    nxt(); #1;
    chk("rst_busy", busy, 0);          chk("rst_wr_s", xa_wr_s, 0);
    chk("rst_rd_s", xa_rd_s, 0);       chk("rst_wdata", xa_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);  chk("rst_rd_id", rd_id, 0);
    chk("rst_rd_data", rd_data, 0);    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);      chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    nxt(); rst_n = 1'b1;

    // Single write from req0
    nxt();
    req0_valid = 1'b1; req0_wr = 1'b1; req0_wdata = 16'hA5A5; #1;
    chk("w1_ready0", req0_ready, 1); chk("w1_ready1", req1_ready, 0);
    nxt(); #1;
    chk("w1_wr_s", xa_wr_s, 1);      chk("w1_wdata", xa_wdata, 16'hA5A5);
    chk("w1_rd_s", xa_rd_s, 0);      chk("w1_busy", busy, 1);
    chk("w1_no_accept", req0_ready, 0);
    req0_valid = 1'b0;
    nxt(); #1;
    chk("w1_wr_s_off", xa_wr_s, 0);  chk("w1_wr_cnt", wr_cnt, 1);
    chk("w1_busy_off", busy, 0);

    // Single read from req1, data presented only in the sampling cycle
    req1_valid = 1'b1; req1_wr = 1'b0; xa_rd_data = 16'hDEAD; #1;
    chk("r1_ready1", req1_ready, 1); chk("r1_ready0", req0_ready, 0);
    nxt(); #1;
    chk("r1_rd_s", xa_rd_s, 1);      chk("r1_wr_s", xa_wr_s, 0);
    chk("r1_no_accept", req1_ready, 0);
    req1_valid = 1'b0;
    nxt(); #1;
    chk("r1_rd_s_off", xa_rd_s, 0);  chk("r1_busy", busy, 1);
    nxt(); xa_rd_data = 16'h1234; #1;
    chk("r1_no_valid_early", rd_valid, 0);
    nxt(); xa_rd_data = 16'hDEAD; #1;
    chk("r1_rd_valid", rd_valid, 1); chk("r1_rd_data", rd_data, 16'h1234);
    chk("r1_rd_id", rd_id, 1);       chk("r1_rd_cnt", rd_cnt, 1);
    chk("r1_idle", busy, 0);
    nxt(); #1;
    chk("r1_pulse_end", rd_valid, 0); chk("r1_hold_data", rd_data, 16'h1234);
    chk("r1_hold_id", rd_id, 1);

    // Both continuously valid with writes: grants alternate starting with req0
    req0_wr = 1'b1; req1_wr = 1'b1;
    req0_wdata = 16'h1000; req1_wdata = 16'h2000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
      chk("rr_gap", xa_wr_s, 0);
      nxt(); #1;
      chk("rr_wr_s", xa_wr_s, 1);
      chk("rr_wdata", xa_wdata, (i % 2 == 1) ? 32'h2000 + 32'(i / 2) : 32'h1000 + 32'(i / 2));
      chk("rr_busy_ready", {30'd0, req0_ready, req1_ready}, 0);
      if (i % 2 == 1) req1_wdata = req1_wdata + 16'd1;
      else            req0_wdata = req0_wdata + 16'd1;
      nxt();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; #1;
    chk("rr_wr_cnt", wr_cnt, 7);

    // Mixed: req0 read vs req1 write; read must finish before req1 is accepted
    req0_valid = 1'b1; req0_wr = 1'b0;
    req1_valid = 1'b1; req1_wr = 1'b1; req1_wdata = 16'h3C3C; #1;
    chk("mx_ready0", req0_ready, 1); chk("mx_ready1", req1_ready, 0);
    nxt(); #1;
    chk("mx_rd_s", xa_rd_s, 1);      chk("mx_wr_s", xa_wr_s, 0);
    chk("mx_ready1_t1", req1_ready, 0);
    req0_valid = 1'b0;
    nxt(); #1;
    chk("mx_ready1_t2", req1_ready, 0);
    chk("mx_excl_t2", 32'(xa_wr_s & xa_rd_s), 0);
    nxt(); xa_rd_data = 16'hBEEF; #1;
    chk("mx_ready1_t3", req1_ready, 0);
    nxt(); xa_rd_data = 16'h0000; #1;
    chk("mx_rd_valid", rd_valid, 1); chk("mx_rd_id", rd_id, 0);
    chk("mx_rd_data", rd_data, 16'hBEEF);
    chk("mx_ready1", req1_ready, 1);  chk("mx_wr_s_t4", xa_wr_s, 0);
    nxt(); #1;
    chk("mx_wr_s_t5", xa_wr_s, 1);    chk("mx_rd_s_t5", xa_rd_s, 0);
    chk("mx_wdata", xa_wdata, 16'h3C3C);
    req1_valid = 1'b0;
    nxt(); #1;
    chk("mx_wr_cnt", wr_cnt, 8);     chk("mx_rd_cnt", rd_cnt, 2);

    // Reset during RD_WAIT of a req0 read
    req0_valid = 1'b1; req0_wr = 1'b0; #1;
    chk("ar_ready0", req0_ready, 1);
    nxt(); #1;
    chk("ar_rd_s", xa_rd_s, 1);
    req0_valid = 1'b0;
    nxt(); #1;
    chk("ar_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("ar_busy_clr", busy, 0);     chk("ar_rd_s_clr", xa_rd_s, 0);
    chk("ar_wr_s_clr", xa_wr_s, 0);  chk("ar_wr_cnt_clr", wr_cnt, 0);
    chk("ar_rd_cnt_clr", rd_cnt, 0); chk("ar_rd_data_clr", rd_data, 0);
    chk("ar_rd_id_clr", rd_id, 0);   chk("ar_wdata_clr", xa_wdata, 0);
    xa_rd_data = 16'h5555;
    nxt(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chk("ar_no_rd_valid", rd_valid, 0);
    end
    req0_valid = 1'b1; req0_wr = 1'b1; req0_wdata = 16'h0F0F;
    req1_valid = 1'b1; req1_wr = 1'b1; req1_wdata = 16'hF0F0; #1;
    chk("ar_tie_ready0", req0_ready, 1); chk("ar_tie_ready1", req1_ready, 0);
    nxt(); #1;
    chk("ar_wr_s", xa_wr_s, 1);      chk("ar_wdata", xa_wdata, 16'h0F0F);
    req0_valid = 1'b0; req1_valid = 1'b0;
    nxt(); #1;
    chk("ar_wr_cnt", wr_cnt, 1);

    // Write counter wrap
    force dut.wr_cnt_q = 16'hFFFF;
    #1;
    release dut.wr_cnt_q;
    #1;
    chk("wrap_preload", wr_cnt, 16'hFFFF);
    req1_valid = 1'b1; req1_wr = 1'b1; req1_wdata = 16'h1111; #1;
    chk("wrap_ready1", req1_ready, 1);
    nxt(); #1;
    chk("wrap_wr_s", xa_wr_s, 1);
    req1_valid = 1'b0;
    nxt(); #1;
    chk("wrap_wr_cnt", wr_cnt, 16'h0000);
    chk("wrap_rd_cnt", rd_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
